ps2: RTL and testbench

- Host-side PS/2 port controller for a bus-attached mouse or keyboard.
- Sits behind the processor's IPIF slave interface (5 CE-decoded registers).
- Drives the open-collector PS2 clock and data lines through external tri-state IOBUFs.
- Receives 11-bit device frames, transmits host-to-device command frames, and raises an interrupt per received byte.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_if.sv | 21 ++
 rtl/ps2_sync_edge.sv | 19 +
 rtl/ps2.sv | 180 ++++++++++++++++++
 tb/tb_ps2.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host port: FSM encoding, register map, status bits.
package ps2_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RECEIVE = 3'd1,
      S_INHIBIT = 3'd2,
      S_REQ     = 3'd3,
      S_SEND    = 3'd4,
      S_ACK     = 3'd5
   } state_t;

   localparam int NUM_REGS   = 5;
   localparam int REG_TX     = 0;
   localparam int REG_RX     = 1;
   localparam int REG_STATUS = 2;
   localparam int REG_CTRL   = 3;
   localparam int REG_SPARE  = 4;

   // CE vectors are MSB-first: register n is strobed on bit (NUM_REGS-1-n)
   localparam int CE_TX     = NUM_REGS - 1 - REG_TX;
   localparam int CE_RX     = NUM_REGS - 1 - REG_RX;
   localparam int CE_STATUS = NUM_REGS - 1 - REG_STATUS;
   localparam int CE_CTRL   = NUM_REGS - 1 - REG_CTRL;

   localparam int STAT_RX_VALID   = 0;
   localparam int STAT_TX_BUSY    = 1;
   localparam int STAT_PARITY_ERR = 2;
   localparam int STAT_ACK_ERR    = 3;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_if.sv
// IPIF slave bus bundle between the processor bus attachment and the PS/2 controller.
interface ps2_if;
   logic [31:0] Bus2IP_Data;
   logic [3:0]  Bus2IP_BE;
   logic [4:0]  Bus2IP_RdCE;
   logic [4:0]  Bus2IP_WrCE;
   logic [31:0] IP2Bus_Data;
   logic        IP2Bus_RdAck;
   logic        IP2Bus_WrAck;
   logic        IP2Bus_Error;

   modport master (
      output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
      input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
   );

   modport slave (
      input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
      output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
   );
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin plus a 1->0 edge detector.
module ps2_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic fall
);
   // Idle PS/2 lines are high; resetting to 1 avoids a false edge after reset
   logic [2:0] sh;

   always_ff @(posedge clk) begin
      if (rst) sh <= 3'b111;
      else     sh <= {sh[1:0], pin};
   end

   assign level = sh[1];
   assign fall  = sh[2] & ~sh[1];
endmodule

// File: rtl/ps2.sv
// PS/2 host port controller: IPIF register slave, RX/TX frame FSM, open-collector line drive.
// Define PS2_PARITY_CHECK_EN to drop received frames with a bad start/stop/parity bit.
module ps2
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic        Bus2IP_Clk,
   input  logic        Bus2IP_Reset,
   ps2_if.slave        bus,
   output logic        IP_Interupt,
   output logic        C_T,
   output logic        C_O,
   input  logic        C_I,
   output logic        D_T,
   output logic        D_O,
   input  logic        D_I,
   output logic [10:0] bitsReceived,
   output logic [11:0] bitsToSend,
   output logic [2:0]  state,
   output logic [14:0] counter,
   output logic        Load,
   output logic [7:0]  LoadVal,
   output logic [7:0]  ReadVal
);

   state_t      st, st_nxt;
   logic [3:0]  bit_cnt;
   logic        rx_valid, parity_err, ack_err, ack_seen, irq_en;
   logic        c_lvl, c_fall, d_lvl, d_fall;
   logic [10:0] rx_shift;
   logic        rx_done, frame_ok, rx_accept, frame_bad, timeout_hit, tx_busy;
   logic        wr_tx, wr_ctrl, rd_rx;

   ps2_sync_edge u_clk_sync (.clk(Bus2IP_Clk), .rst(Bus2IP_Reset), .pin(C_I), .level(c_lvl), .fall(c_fall));
   ps2_sync_edge u_dat_sync (.clk(Bus2IP_Clk), .rst(Bus2IP_Reset), .pin(D_I), .level(d_lvl), .fall(d_fall));

   assign wr_tx   = bus.Bus2IP_WrCE[CE_TX];
   assign wr_ctrl = bus.Bus2IP_WrCE[CE_CTRL];
   assign rd_rx   = bus.Bus2IP_RdCE[CE_RX];

   // Frame is LSB-first: after 11 shifts [0]=start, [8:1]=data, [9]=parity, [10]=stop
   assign rx_shift    = {d_lvl, bitsReceived[10:1]};
   assign rx_done     = (st == S_RECEIVE) && c_fall && (bit_cnt == 4'd10);
   assign frame_ok    = ~rx_shift[0] & rx_shift[10] & (^rx_shift[9:1]);
   assign timeout_hit = !c_fall && (counter >= 15'(TIMEOUT_CYCLES - 1));
   assign tx_busy     = !(st == S_IDLE || st == S_RECEIVE);

`ifdef PS2_PARITY_CHECK_EN
   assign rx_accept = frame_ok;
   assign frame_bad = ~frame_ok;
`else
   assign rx_accept = 1'b1;
   assign frame_bad = 1'b0;
`endif

   logic unused_ok;
   assign unused_ok = ^{bus.Bus2IP_BE, bus.Bus2IP_Data[31:8], d_fall, frame_ok};

   always_comb begin
      st_nxt = st;
      C_T    = 1'b1;
      C_O    = 1'b0;
      D_T    = 1'b1;
      D_O    = 1'b0;
      case (st)
         // A device start bit takes priority over a same-cycle TX register write
         S_IDLE: begin
            if (c_fall && !d_lvl) st_nxt = S_RECEIVE;
            else if (wr_tx)       st_nxt = S_INHIBIT;
         end
         S_RECEIVE: begin
            if (rx_done || timeout_hit) st_nxt = S_IDLE;
         end
         S_INHIBIT: begin
            C_T = 1'b0;
            if (counter == 15'(INHIBIT_CYCLES - 1)) st_nxt = S_REQ;
         end
         S_REQ: begin
            D_T    = 1'b0;
            st_nxt = S_SEND;
         end
         // Start bit is already on the line; each device fall presents the next bit
         S_SEND: begin
            D_T = 1'b0;
            D_O = bitsToSend[0];
            if (c_fall && bit_cnt == 4'd9) st_nxt = S_ACK;
            else if (timeout_hit)          st_nxt = S_IDLE;
         end
         S_ACK: begin
            if (ack_seen && c_lvl && d_lvl) st_nxt = S_IDLE;
            else if (timeout_hit)           st_nxt = S_IDLE;
         end
         default: st_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Bus2IP_Clk) begin
      if (Bus2IP_Reset) begin
         st           <= S_IDLE;
         bitsReceived <= '0;
         bitsToSend   <= '0;
         counter      <= '0;
         bit_cnt      <= '0;
         Load         <= 1'b0;
         LoadVal      <= '0;
         ReadVal      <= '0;
         rx_valid     <= 1'b0;
         parity_err   <= 1'b0;
         ack_err      <= 1'b0;
         ack_seen     <= 1'b0;
         irq_en       <= 1'b1;
      end else begin
         st   <= st_nxt;
         Load <= 1'b0;

         if (st_nxt != st || st == S_IDLE || st == S_REQ ||
             (c_fall && st inside {S_RECEIVE, S_SEND, S_ACK}))
            counter <= '0;
         else
            counter <= counter + 15'd1;

         if (st == S_IDLE) begin
            ack_seen <= 1'b0;
            if (st_nxt == S_RECEIVE) begin
               bitsReceived <= rx_shift;
               bit_cnt      <= 4'd1;
            end else if (st_nxt == S_INHIBIT) begin
               Load       <= 1'b1;
               LoadVal    <= bus.Bus2IP_Data[7:0];
               bitsToSend <= {2'b11, odd_parity(bus.Bus2IP_Data[7:0]), bus.Bus2IP_Data[7:0], 1'b0};
               bit_cnt    <= 4'd0;
            end
         end

         if (st == S_RECEIVE && c_fall) begin
            bitsReceived <= rx_shift;
            bit_cnt      <= bit_cnt + 4'd1;
         end

         if (st == S_SEND && c_fall) begin
            bitsToSend <= {1'b0, bitsToSend[11:1]};
            bit_cnt    <= bit_cnt + 4'd1;
         end

         if (st == S_ACK && c_fall && !ack_seen) begin
            ack_err  <= d_lvl;
            ack_seen <= 1'b1;
         end

         // A completing frame beats a same-cycle RX read so the new byte is not lost
         if (rx_done && rx_accept) begin
            ReadVal  <= rx_shift[8:1];
            rx_valid <= 1'b1;
         end else if (rd_rx) begin
            rx_valid <= 1'b0;
         end

         if (rx_done) parity_err <= frame_bad;
         if (wr_ctrl) irq_en     <= bus.Bus2IP_Data[0];
      end
   end

   always_comb begin
      bus.IP2Bus_Data = '0;
      if (bus.Bus2IP_RdCE[CE_TX])          bus.IP2Bus_Data = {24'd0, LoadVal};
      else if (bus.Bus2IP_RdCE[CE_RX])     bus.IP2Bus_Data = {24'd0, ReadVal};
      else if (bus.Bus2IP_RdCE[CE_STATUS]) bus.IP2Bus_Data = {28'd0, ack_err, parity_err, tx_busy, rx_valid};
      else if (bus.Bus2IP_RdCE[CE_CTRL])   bus.IP2Bus_Data = {31'd0, irq_en};
   end

   assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
   assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
   assign bus.IP2Bus_Error = 1'b0;

   assign IP_Interupt = rx_valid & irq_en;
   assign state       = st;

endmodule

// File: tb/tb_ps2.sv
// Self-checking bench for ps2: behavioural PS/2 device model plus expected-byte queue.
`timescale 1ns/1ps
module tb_ps2;
   localparam int HALF = 40;
   localparam int INH  = 10000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ps2_if bus();

   logic        irq, c_t, c_o, c_i, d_t, d_o, d_i, load;
   logic [10:0] bits_rx;
   logic [11:0] bits_tx;
   logic [2:0]  st;
   logic [14:0] cnt;
   logic [7:0]  load_val, read_val;
   logic        dev_clk = 1'b1;
   logic        dev_dat = 1'b1;

   // Open-collector wired-AND of host and device drivers
   assign c_i = dev_clk & (c_t | c_o);
   assign d_i = dev_dat & (d_t | d_o);

   ps2 dut (
      .Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .bus(bus), .IP_Interupt(irq),
      .C_T(c_t), .C_O(c_o), .C_I(c_i), .D_T(d_t), .D_O(d_o), .D_I(d_i),
      .bitsReceived(bits_rx), .bitsToSend(bits_tx), .state(st), .counter(cnt),
      .Load(load), .LoadVal(load_val), .ReadVal(read_val)
   );

   int vectors = 0;
   int miscompares = 0;
   int load_pulses = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_rx = 8'h00;

   always @(negedge clk) if (load === 1'b1) load_pulses++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
      return {1'b1, (~^b) ^ bad, b, 1'b0};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input int idx, input logic [31:0] v);
      @(negedge clk);
      bus.Bus2IP_WrCE = 5'(1 << (4 - idx));
      bus.Bus2IP_Data = v;
      @(negedge clk);
      bus.Bus2IP_WrCE = '0;
      bus.Bus2IP_Data = '0;
   endtask

   task automatic bus_read(input int idx, output logic [31:0] v);
      @(negedge clk);
      bus.Bus2IP_RdCE = 5'(1 << (4 - idx));
      #1 v = bus.IP2Bus_Data;
      @(negedge clk);
      bus.Bus2IP_RdCE = '0;
   endtask

   task automatic send_bits(input logic [10:0] f, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         dev_dat = f[i];
         tick(HALF / 2);
         dev_clk = 1'b0;
         tick(HALF);
         dev_clk = 1'b1;
         tick(HALF / 2);
      end
      dev_dat = 1'b1;
   endtask

   // Device side of a host-to-device frame: clocks 10 bits in, then the ack slot
   task automatic dev_rx(input logic ack_low, output logic [9:0] got, output logic ok);
      int n = 0;
      ok = 1'b1;
      got = '0;
      while (c_i === 1'b0 && n < 30000) begin n++; tick(1); end
      if (n >= 30000) ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(HALF / 2);
         dev_clk = 1'b0;
         tick(HALF);
         dev_clk = 1'b1;
         got[i] = d_i;
         tick(HALF / 2);
      end
      dev_dat = ack_low ? 1'b0 : 1'b1;
      tick(HALF / 2);
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      tick(HALF / 2);
      dev_dat = 1'b1;
      tick(10);
   endtask

   task automatic test_reset();
      logic [31:0] r;
      bus.Bus2IP_Data = '0; bus.Bus2IP_BE = 4'hF; bus.Bus2IP_RdCE = '0; bus.Bus2IP_WrCE = '0;
      rst = 1'b1;
      tick(4);
      rst = 1'b0;
      tick(1);
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
      vectors++; if ({c_t, d_t, c_o, d_o} !== 4'b1100) begin miscompares++; $display("FAIL reset_lines: got %b expected 1100", {c_t, d_t, c_o, d_o}); end
      vectors++; if (st !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", st); end
      vectors++; if (load !== 1'b0 || bits_rx !== 11'd0 || bits_tx !== 12'd0) begin miscompares++; $display("FAIL reset_regs: got load=%b rx=%h tx=%h expected zeros", load, bits_rx, bits_tx); end
      vectors++; if (bus.IP2Bus_Data !== 32'd0 || bus.IP2Bus_Error !== 1'b0) begin miscompares++; $display("FAIL idle_bus: got data=%h err=%b expected 0", bus.IP2Bus_Data, bus.IP2Bus_Error); end
      @(negedge clk);
      bus.Bus2IP_RdCE = 5'b00010;
      #1;
      vectors++; if (bus.IP2Bus_RdAck !== 1'b1 || bus.IP2Bus_Data !== 32'd1) begin miscompares++; $display("FAIL reset_ctrl: got ack=%b data=%h expected 1/1", bus.IP2Bus_RdAck, bus.IP2Bus_Data); end
      @(negedge clk);
      bus.Bus2IP_RdCE = '0;
      bus_read(4, r);
      vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL reg4_zero: got %h expected 0", r); end
      bus_read(2, r);
      vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL reset_status: got %h expected 0", r); end
   endtask

   task automatic test_tx();
      logic [31:0] r;
      logic [9:0]  got;
      logic        ok;
      int          n, lp;
      lp = load_pulses;
      bus_write(0, 32'h4B);
      vectors++; if (load !== 1'b1 || load_val !== 8'h4B) begin miscompares++; $display("FAIL load_pulse: got load=%b val=%h expected 1/4b", load, load_val); end
      n = 0;
      while (c_i === 1'b0 && n < 15000) begin n++; tick(1); end
      vectors++; if (n !== INH) begin miscompares++; $display("FAIL inhibit_len: got %0d expected %0d", n, INH); end
      vectors++; if (d_i !== 1'b0) begin miscompares++; $display("FAIL req_data: got %b expected 0", d_i); end
      dev_rx(1'b1, got, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL tx_wait: got timeout expected clock release"); end
      vectors++; if (got !== {1'b1, 1'b1, 8'h4B}) begin miscompares++; $display("FAIL tx_bits: got %b expected %b", got, {1'b1, 1'b1, 8'h4B}); end
      bus_read(2, r);
      vectors++; if (r[3:1] !== 3'b000) begin miscompares++; $display("FAIL tx_status: got %b expected 000", r[3:1]); end
      vectors++; if (load_pulses - lp !== 1) begin miscompares++; $display("FAIL load_count: got %0d expected 1", load_pulses - lp); end
      bus_read(0, r);
      vectors++; if (r !== 32'h4B) begin miscompares++; $display("FAIL tx_readback: got %h expected 4b", r); end
   endtask

   task automatic test_tx_nack_busy();
      logic [31:0] r;
      logic [9:0]  got;
      logic [7:0]  b;
      logic        ok;
      int          lp;
      b = 8'($urandom);
      lp = load_pulses;
      bus_write(0, {24'd0, b});
      tick(50);
      bus_read(2, r);
      vectors++; if (r[1] !== 1'b1) begin miscompares++; $display("FAIL busy_flag: got %b expected 1", r[1]); end
      bus_write(0, {24'd0, ~b});
      bus_read(0, r);
      vectors++; if (r !== {24'd0, b}) begin miscompares++; $display("FAIL busy_write: got %h expected %h", r, b); end
      dev_rx(1'b0, got, ok);
      vectors++; if (ok !== 1'b1 || got !== {1'b1, ~^b, b}) begin miscompares++; $display("FAIL tx_rand: got %b expected %b", got, {1'b1, ~^b, b}); end
      bus_read(2, r);
      vectors++; if (r[3:1] !== 3'b100) begin miscompares++; $display("FAIL ack_err: got %b expected 100", r[3:1]); end
      vectors++; if (load_pulses - lp !== 1) begin miscompares++; $display("FAIL busy_load: got %0d expected 1", load_pulses - lp); end
   endtask

   task automatic test_rx_single();
      logic [31:0] r;
      logic [10:0] f;
      f = mk_frame(8'hFA, 1'b0);
      send_bits(f, 0, 9);
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b expected 0", irq); end
      send_bits(f, 10, 10);
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rise: got %b expected 1", irq); end
      bus_read(1, r);
      vectors++; if (r !== 32'hFA) begin miscompares++; $display("FAIL rx_fa: got %h expected fa", r); end
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b expected 0", irq); end
      last_rx = 8'hFA;
   endtask

   task automatic test_stream();
      logic [31:0] r;
      logic [7:0]  b, e;
      for (int i = 0; i < 8; i++) begin
         b = (i == 0) ? 8'h08 : (i == 1) ? 8'h01 : (i == 2) ? 8'hFF : 8'($urandom);
         exp_q.push_back(b);
         send_bits(mk_frame(b, 1'b0), 0, 10);
         vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL stream_irq%0d: got %b expected 1", i, irq); end
         bus_read(1, r);
         e = exp_q.pop_front();
         vectors++; if (r !== {24'd0, e} || read_val !== e) begin miscompares++; $display("FAIL stream_byte%0d: got %h expected %h", i, r, e); end
         vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL stream_clr%0d: got %b expected 0", i, irq); end
         last_rx = e;
      end
   endtask

   // Second frame completes in the same cycle the pending first byte is read
   task automatic test_back_to_back();
      logic [31:0] r;
      logic [7:0]  a, b;
      logic [10:0] f;
      a = 8'($urandom);
      b = ~a;
      send_bits(mk_frame(a, 1'b0), 0, 10);
      f = mk_frame(b, 1'b0);
      send_bits(f, 0, 9);
      dev_dat = f[10];
      tick(HALF / 2);
      dev_clk = 1'b0;
      tick(2);
      bus.Bus2IP_RdCE = 5'b01000;
      #1 r = bus.IP2Bus_Data;
      tick(1);
      bus.Bus2IP_RdCE = '0;
      tick(HALF - 3);
      dev_clk = 1'b1;
      tick(HALF / 2);
      vectors++; if (r !== {24'd0, a}) begin miscompares++; $display("FAIL collide_old: got %h expected %h", r, a); end
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL collide_set: got %b expected 1", irq); end
      bus_read(1, r);
      vectors++; if (r !== {24'd0, b}) begin miscompares++; $display("FAIL collide_new: got %h expected %h", r, b); end
      last_rx = b;
   endtask

   task automatic test_irq_mask();
      logic [31:0] r;
      logic [7:0]  b;
      b = 8'($urandom);
      bus_write(3, 32'd0);
      send_bits(mk_frame(b, 1'b0), 0, 10);
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL mask_irq: got %b expected 0", irq); end
      bus_read(2, r);
      vectors++; if (r[0] !== 1'b1) begin miscompares++; $display("FAIL mask_valid: got %b expected 1", r[0]); end
      bus_write(3, 32'd1);
      tick(1);
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL unmask_irq: got %b expected 1", irq); end
      bus_read(1, r);
      vectors++; if (r !== {24'd0, b}) begin miscompares++; $display("FAIL mask_byte: got %h expected %h", r, b); end
      last_rx = b;
   endtask

   task automatic test_timeout();
      logic [31:0] r;
      logic [7:0]  b;
      int          n;
      b = 8'($urandom);
      send_bits(mk_frame(b, 1'b0), 0, 4);
      vectors++; if (st !== 3'd1) begin miscompares++; $display("FAIL trunc_state: got %0d expected 1", st); end
      n = 0;
      while (st !== 3'd0 && n < 25000) begin n++; tick(1); end
      vectors++; if (n < 19000 || n > 20010) begin miscompares++; $display("FAIL timeout_len: got %0d expected about 20000", n); end
      vectors++; if (irq !== 1'b0 || c_t !== 1'b1 || d_t !== 1'b1) begin miscompares++; $display("FAIL timeout_idle: got irq=%b ct=%b dt=%b expected 0/1/1", irq, c_t, d_t); end
      b = ~b;
      send_bits(mk_frame(b, 1'b0), 0, 10);
      bus_read(1, r);
      vectors++; if (r !== {24'd0, b}) begin miscompares++; $display("FAIL recover_byte: got %h expected %h", r, b); end
      last_rx = b;
   endtask

   task automatic test_parity();
      logic [31:0] r;
      logic [7:0]  b;
      b = 8'($urandom);
      send_bits(mk_frame(b, 1'b1), 0, 10);
      bus_read(2, r);
`ifdef PS2_PARITY_CHECK_EN
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL par_irq: got %b expected 0", irq); end
      vectors++; if (r[2] !== 1'b1 || r[0] !== 1'b0) begin miscompares++; $display("FAIL par_status: got %b expected perr=1 valid=0", r[3:0]); end
      bus_read(1, r);
      vectors++; if (r !== {24'd0, last_rx}) begin miscompares++; $display("FAIL par_keep: got %h expected %h", r, last_rx); end
`else
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL par_irq: got %b expected 1", irq); end
      vectors++; if (r[2] !== 1'b0 || r[0] !== 1'b1) begin miscompares++; $display("FAIL par_status: got %b expected perr=0 valid=1", r[3:0]); end
      bus_read(1, r);
      vectors++; if (r !== {24'd0, b}) begin miscompares++; $display("FAIL par_latch: got %h expected %h", r, b); end
`endif
   endtask

   initial begin
      test_reset();
      test_tx();
      test_tx_nack_busy();
      test_rx_single();
      test_stream();
      test_back_to_back();
      test_irq_mask();
      test_timeout();
      test_parity();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
